// File: rtl/if_id_queue_if.sv
// Fetch/decode-facing bundle of the IF/ID decoupling queue.
// The master side is fetch+decode; the slave side is the queue itself.
interface if_id_queue_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_instruction;
   logic            in_ready;
   logic            fetch_stall;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instruction;
   logic            out_is_cf;

   modport master (
      output in_valid, in_pc, in_instruction, flush, out_ready,
      input  in_ready, fetch_stall, out_valid, out_pc, out_instruction, out_is_cf
   );

   modport slave (
      input  in_valid, in_pc, in_instruction, flush, out_ready,
      output in_ready, fetch_stall, out_valid, out_pc, out_instruction, out_is_cf
   );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of {pc, instruction} pairs with
// flush, fetch back-pressure and an early control-flow predecode on the head.
module if_id_queue #(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013)
) (
   input  logic                   clk,
   input  logic                   rst,
   if_id_queue_if.slave           q,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] insn_mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   logic          not_full;
   logic          not_empty;
   logic          push;
   logic          pop;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_insn;
   logic            head_cf;

   // Ready/valid come from registered occupancy only, so there is no
   // combinational path from out_ready back to fetch.
   assign not_full  = (count_reg != FULL);
   assign not_empty = (count_reg != '0);
   assign push      = q.in_valid && not_full;
   assign pop       = q.out_ready && not_empty;

   assign q.in_ready    = not_full;
   assign q.fetch_stall = !not_full;
   assign q.out_valid   = not_empty;
   assign count         = count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (q.flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage carries no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push && !q.flush) begin
         pc_mem[wr_ptr_reg]   <= q.in_pc;
         insn_mem[wr_ptr_reg] <= q.in_instruction;
      end
   end

   always_comb begin
      head_pc   = '0;
      head_insn = NOP_INSN;
      head_cf   = 1'b0;
      if (not_empty) begin
         head_pc   = pc_mem[rd_ptr_reg];
         head_insn = insn_mem[rd_ptr_reg];
         // Branch, JAL and JALR opcodes.
         head_cf   = (head_insn[6:0] == 7'b1100011) ||
                     (head_insn[6:0] == 7'b1101111) ||
                     (head_insn[6:0] == 7'b1100111);
      end
   end

   assign q.out_pc          = head_pc;
   assign q.out_instruction = head_insn;
   assign q.out_is_cf       = head_cf;
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_if_id_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;

   logic [63:0] mq[$];

   if_id_queue_if #(.XLEN(XLEN)) bus ();

   if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSN(NOP)) dut (
      .clk   (clk),
      .rst   (rst),
      .q     (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_cf(input logic [31:0] insn);
      return (insn[6:0] inside {7'h63, 7'h6F, 7'h67});
   endfunction

   task automatic check_all(input string tag);
      logic [31:0] e_pc, e_insn;
      int n;
      n      = mq.size();
      e_pc   = (n != 0) ? mq[0][63:32] : 32'h0;
      e_insn = (n != 0) ? mq[0][31:0]  : NOP;
      chk({tag, ".count"},     32'(count),                  32'(n));
      chk({tag, ".out_valid"}, 32'(bus.out_valid),          32'(n != 0));
      chk({tag, ".in_ready"},  32'(bus.in_ready),           32'(n != DEPTH));
      chk({tag, ".stall"},     32'(bus.fetch_stall),        32'(n == DEPTH));
      chk({tag, ".out_pc"},    bus.out_pc,                  e_pc);
      chk({tag, ".out_insn"},  bus.out_instruction,         e_insn);
      chk({tag, ".out_is_cf"}, 32'(bus.out_is_cf),          32'((n != 0) && model_cf(e_insn)));
   endtask

   // One clock transaction: drive, clock, update model, check at negedge.
   task automatic step(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] insn, input logic rdy, input logic fl);
      logic do_push, do_pop;
      bus.in_valid       = v;
      bus.in_pc          = pc;
      bus.in_instruction = insn;
      bus.out_ready      = rdy;
      bus.flush          = fl;
      do_push = v && (mq.size() != DEPTH);
      do_pop  = rdy && (mq.size() != 0);
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back({pc, insn});
      end
      @(negedge clk);
      $display("%s: v=%0b pc=%h insn=%h rdy=%0b fl=%0b -> count=%0d head_pc=%h cf=%0b",
               tag, v, pc, insn, rdy, fl, count, bus.out_pc, bus.out_is_cf);
      check_all(tag);
   endtask

   initial begin
      bus.in_valid       = 1'b0;
      bus.in_pc          = '0;
      bus.in_instruction = '0;
      bus.out_ready      = 1'b0;
      bus.flush          = 1'b0;

      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Fill to full, fifth offer ignored, then drain in order.
      for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'(i * 4), NOP, 1'b0, 1'b0);
      step("full_ignore", 1'b1, 32'h10, NOP, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", bus.out_pc, 32'(i * 4));
         step("drain", 1'b0, 32'h0, NOP, 1'b1, 1'b0);
      end

      // Single-cycle latency into an empty queue.
      step("latency", 1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
      chk("latency.pc", bus.out_pc, 32'h100);
      step("latency_pop", 1'b0, 32'h0, NOP, 1'b1, 1'b0);

      // Steady push+pop at count 2 wraps both pointers.
      step("pre2a", 1'b1, 32'h200, NOP, 1'b0, 1'b0);
      step("pre2b", 1'b1, 32'h204, NOP, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step("pushpop", 1'b1, 32'(32'h208 + i * 4), NOP, 1'b1, 1'b0);

      // Flush beats a simultaneous push at count 3.
      step("pre3", 1'b1, 32'h300, NOP, 1'b0, 1'b0);
      step("flush", 1'b1, 32'h304, 32'h0000_0063, 1'b0, 1'b1);
      chk("flush.insn", bus.out_instruction, NOP);
      step("post_flush", 1'b1, 32'h400, 32'h0010_0113, 1'b0, 1'b0);
      step("post_flush_pop", 1'b0, 32'h0, NOP, 1'b1, 1'b0);

      // Control-flow predecode on the head.
      step("cf_beq",  1'b1, 32'h500, 32'h0000_0063, 1'b0, 1'b0);
      step("cf_jal",  1'b1, 32'h504, 32'h0000_006F, 1'b0, 1'b0);
      step("cf_jalr", 1'b1, 32'h508, 32'h0000_8067, 1'b0, 1'b0);
      step("cf_addi", 1'b1, 32'h50C, 32'h0000_0013, 1'b0, 1'b0);
      chk("cf.beq", 32'(bus.out_is_cf), 32'd1);
      step("cf_pop1", 1'b0, 32'h0, NOP, 1'b1, 1'b0);
      chk("cf.jal", 32'(bus.out_is_cf), 32'd1);
      step("cf_pop2", 1'b0, 32'h0, NOP, 1'b1, 1'b0);
      chk("cf.jalr", 32'(bus.out_is_cf), 32'd1);
      step("cf_pop3", 1'b0, 32'h0, NOP, 1'b1, 1'b0);
      chk("cf.addi", 32'(bus.out_is_cf), 32'd0);
      step("cf_pop4", 1'b0, 32'h0, NOP, 1'b1, 1'b0);

      // Asynchronous reset between edges at count 3.
      for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 32'(32'h600 + i * 4), NOP, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      mq.delete();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step("after_rst", 1'b1, 32'h700, 32'h0000_006F, 1'b0, 1'b0);
      step("after_rst_pop", 1'b0, 32'h0, NOP, 1'b1, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] insn;
         logic [6:0]  ops[5];
         ops = '{7'h63, 7'h6F, 7'h67, 7'h13, 7'h33};
         insn = {$urandom()} & 32'hFFFF_FF80;
         insn[6:0] = ops[$urandom_range(0, 4)];
         step("rand", 1'($urandom_range(0, 3) != 0), $urandom(), insn,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Decoupling buffer between the instruction fetch unit and the decode stage. It captures each fetched {pc, instruction} pair and presents the pairs to decode in order over a valid/ready handshake. It back-pressures fetch through a stall output. It discards all queued entries when a taken branch redirects fetch. It also predecodes a control-flow flag so decode and the hazard logic get it early.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
XLEN, 32, width of the pc and instruction fields
NOP_INSN, 32'h0000_0013, instruction word driven on out_instruction when the queue is empty

Ports:
clk  input  1  clock, all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  fetch presents a valid instruction this cycle
in_pc  input  XLEN  pc of the presented instruction
in_instruction  input  XLEN  fetched instruction word
in_ready  output  1  queue can accept an entry this cycle
fetch_stall  output  1  stall request to fetch; always equal to !in_ready
flush  input  1  taken-branch or redirect flush; synchronous
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes the head entry this cycle
out_pc  output  XLEN  pc of the head entry
out_instruction  output  XLEN  head instruction word
out_is_cf  output  1  head is control flow: opcode[6:0] is 1100011, 1101111 or 1100111
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, instruction}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - An occupancy counter tracks fill level.
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: out_valid=0, out_pc=0, out_instruction=NOP_INSN, out_is_cf=0, in_ready=1.
  - Entry storage needs no reset.
- Handshake definitions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
- Head outputs:
  - Driven combinationally from the entry at rd_ptr when count != 0.
  - When empty: out_pc=0, out_instruction=NOP_INSN, out_is_cf=0.
  - out_is_cf is computed from the head instruction's opcode.
- Latency: an entry pushed at rising edge N appears on out_* in the cycle after edge N. There is no same-cycle bypass.
- Per-edge update, when flush=0:
  - push only: write entry at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop together: write, both pointers advance, count unchanged. Legal at any count 1..DEPTH-1. At count=DEPTH, push cannot occur because in_ready=0.
  - neither: state holds.
- Flush has highest priority:
  - At the edge where flush=1: count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop in that cycle is discarded. The entry offered by fetch is not stored.
  - out_valid is low the following cycle.
- Full: count=DEPTH gives in_ready=0 and fetch_stall=1. in_valid is ignored.
- Empty: out_ready is ignored and the pointers do not move.
- Fetch holds in_pc and in_instruction stable while in_valid=1 and in_ready=0.
- Decode may deassert out_ready at any time. The head entry holds until it is popped or flushed.
- count never exceeds DEPTH and never underflows. Verification asserts this, plus pointer consistency: wr_ptr - rd_ptr ≡ count (mod DEPTH).
- Reset asserted mid-operation clears all state immediately. The first push after rst deasserts lands at entry 0.

Test Plan:
- Fill to full: push pcs 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0, fetch_stall=1. A 5th in_valid with pc 0x10 is ignored. Then pop four -> out_pc sequence 0x00,0x04,0x08,0x0C.
- Latency: push pc 0x100, insn 0x00500093 into an empty queue -> out_valid rises the next cycle with exactly those values; out_is_cf=0.
- Simultaneous push/pop at count=2 for 8 cycles -> count stays 2, order preserved, pointers wrap past DEPTH-1 with no gap or duplicate.
- Flush with push: count=3 with in_valid=1 and flush=1 on the same edge -> next cycle count=0, out_valid=0, out_instruction=0x00000013. The next push appears as the head.
- Predecode: push 0x00000063 (beq), 0x0000006F (jal), 0x00008067 (jalr), 0x00000013 -> out_is_cf = 1,1,1,0.
- Async reset mid-stream: rst=1 between clock edges at count=3 -> count=0, out_valid=0, in_ready=1 immediately, without waiting for a clock edge. Traffic after release starts cleanly.
